// File: rtl/cpu_bus_responder_if.sv
// CPU-side 6502 bus bundle: address, direction, write data in; read data, bus enable, RDY out.
// Latency: pure wiring, no storage.
// Backpressure: the responder drives rdy low to stall CPU reads; writes are never stalled.
interface cpu_bus_responder_if;
  logic [15:0] addr;
  logic        rw;
  logic [7:0]  data_from_cpu;
  logic [7:0]  data_to_cpu;
  logic        data_oe;
  logic        rdy;

  modport master (
    output addr, rw, data_from_cpu,
    input  data_to_cpu, data_oe, rdy
  );

  modport slave (
    input  addr, rw, data_from_cpu,
    output data_to_cpu, data_oe, rdy
  );
endinterface

// File: rtl/cpu_bus_responder.sv
// Small generic synchronous FIFO with valid/ready on both sides.
// Latency: a pushed entry is visible at rd_dat on the cycle after the push.
// Backpressure: wr_rdy drops when full unless a pop happens on the same edge.
module cpu_bus_responder_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_vld,
  input  logic [WIDTH-1:0] wr_dat,
  output logic             wr_rdy,
  output logic             rd_vld,
  output logic [WIDTH-1:0] rd_dat,
  input  logic             rd_rdy
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_wr, do_rd;

  assign rd_vld = (cnt_q != '0);
  assign do_rd  = rd_rdy & rd_vld;
  assign wr_rdy = (cnt_q != FULL_CNT) | do_rd;
  assign do_wr  = wr_vld & wr_rdy;
  assign rd_dat = mem_q[rptr_q];

  // Next pointers, occupancy and storage; simultaneous push/pop keeps the count.
  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (do_wr) begin
      mem_d[wptr_q] = wr_dat;
      wptr_d        = wptr_q + AW'(1);
    end
    if (do_rd) begin
      rptr_d = rptr_q + AW'(1);
    end
    if (do_wr && !do_rd) begin
      cnt_d = cnt_q + (AW+1)'(1);
    end else if (do_rd && !do_wr) begin
      cnt_d = cnt_q - (AW+1)'(1);
    end
  end

  // FIFO state registers; reset empties the queue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q  <= '{default: '0};
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end
endmodule

// 6502 bus target: posts window writes into a FIFO, stalls window reads until the backend answers.
// Latency: read hit in cycle N with idle backend and empty FIFO returns data in N+2 at the earliest.
// Backpressure: rdy low stalls CPU reads; full FIFO drops writes and raises sticky ovf.
module cpu_bus_responder #(
  parameter logic [15:0] BASE        = 16'hC000,
  parameter int          ADDR_W      = 8,
  parameter int          TIMEOUT     = 16,
  parameter int          WFIFO_DEPTH = 2
) (
  input  logic              phi2,
  input  logic              rst,
  cpu_bus_responder_if.slave bus,
  output logic              dev_req,
  output logic              dev_we,
  output logic [ADDR_W-1:0] dev_addr,
  output logic [7:0]        dev_wdata,
  input  logic [7:0]        dev_rdata,
  input  logic              dev_ack,
  input  logic              clr_flags,
  output logic              err,
  output logic              ovf
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int FW = ADDR_W + 8;

  typedef enum logic [1:0] {IDLE, WREQ, RREQ, RDONE} state_t;

  state_t            state_q, state_d;
  logic              dev_req_q, dev_req_d;
  logic              dev_we_q, dev_we_d;
  logic [ADDR_W-1:0] dev_addr_q, dev_addr_d;
  logic [7:0]        dev_wdata_q, dev_wdata_d;
  logic [7:0]        rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              ovf_q, ovf_d;
  logic [TW-1:0]     timer_q, timer_d;

  logic              sel, cpu_rd, cpu_wr;
  logic              fifo_wr_rdy, fifo_rd_vld, fifo_rd_rdy;
  logic [FW-1:0]     fifo_rd_dat;
  logic              ovf_set, err_set;
  logic [TW-1:0]     timer_inc;
  logic              tmo;

  assign sel    = (bus.addr[15:ADDR_W] == BASE[15:ADDR_W]);
  assign cpu_rd = sel & bus.rw;
  assign cpu_wr = sel & ~bus.rw;

  // The FIFO head is only consumed while the FSM sits in IDLE.
  assign fifo_rd_rdy = (state_q == IDLE);

  cpu_bus_responder_fifo #(
    .WIDTH (FW),
    .DEPTH (WFIFO_DEPTH)
  ) u_wfifo (
    .clk    (phi2),
    .rst    (rst),
    .wr_vld (cpu_wr),
    .wr_dat ({bus.addr[ADDR_W-1:0], bus.data_from_cpu}),
    .wr_rdy (fifo_wr_rdy),
    .rd_vld (fifo_rd_vld),
    .rd_dat (fifo_rd_dat),
    .rd_rdy (fifo_rd_rdy)
  );

  assign ovf_set   = cpu_wr & ~fifo_wr_rdy;
  assign timer_inc = timer_q + TW'(1);
  assign tmo       = (timer_inc == TW'(TIMEOUT));

  // RDY only ever stalls window reads; the RDONE cycle releases the CPU with data on the bus.
  assign bus.rdy         = ~cpu_rd | (state_q == RDONE);
  assign bus.data_oe     = cpu_rd & (state_q == RDONE);
  assign bus.data_to_cpu = rdata_q;
  assign dev_req         = dev_req_q;
  assign dev_we          = dev_we_q;
  assign dev_addr        = dev_addr_q;
  assign dev_wdata       = dev_wdata_q;
  assign err             = err_q;
  assign ovf             = ovf_q;

  // Next-state logic: posted writes drain before any read is issued so reads see prior writes.
  always_comb begin
    state_d     = state_q;
    dev_req_d   = dev_req_q;
    dev_we_d    = dev_we_q;
    dev_addr_d  = dev_addr_q;
    dev_wdata_d = dev_wdata_q;
    rdata_d     = rdata_q;
    timer_d     = timer_q;
    err_set     = 1'b0;
    case (state_q)
      IDLE: begin
        if (fifo_rd_vld) begin
          dev_addr_d  = fifo_rd_dat[FW-1:8];
          dev_wdata_d = fifo_rd_dat[7:0];
          dev_we_d    = 1'b1;
          dev_req_d   = 1'b1;
          timer_d     = '0;
          state_d     = WREQ;
        end else if (cpu_rd) begin
          dev_addr_d = bus.addr[ADDR_W-1:0];
          dev_we_d   = 1'b0;
          dev_req_d  = 1'b1;
          timer_d    = '0;
          state_d    = RREQ;
        end
      end
      WREQ: begin
        if (dev_ack || tmo) begin
          dev_req_d = 1'b0;
          err_set   = ~dev_ack;
          state_d   = IDLE;
        end else begin
          timer_d = timer_inc;
        end
      end
      RREQ: begin
        if (dev_ack || tmo) begin
          dev_req_d = 1'b0;
          err_set   = ~dev_ack;
          if (cpu_rd) begin
            rdata_d = dev_ack ? dev_rdata : 8'hFF;
            state_d = RDONE;
          end else begin
            state_d = IDLE;
          end
        end else begin
          timer_d = timer_inc;
        end
      end
      RDONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // A set event on the same edge as a clear wins.
    err_d = (err_q & ~clr_flags) | err_set;
    ovf_d = (ovf_q & ~clr_flags) | ovf_set;
  end

  // FSM and registered outputs; reset abandons any in-flight transaction.
  always_ff @(posedge phi2 or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      dev_req_q   <= 1'b0;
      dev_we_q    <= 1'b0;
      dev_addr_q  <= '0;
      dev_wdata_q <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      ovf_q       <= 1'b0;
      timer_q     <= '0;
    end else begin
      state_q     <= state_d;
      dev_req_q   <= dev_req_d;
      dev_we_q    <= dev_we_d;
      dev_addr_q  <= dev_addr_d;
      dev_wdata_q <= dev_wdata_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      ovf_q       <= ovf_d;
      timer_q     <= timer_d;
    end
  end
endmodule
